// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared BCD constants and FSM state encoding for the digit-serial BCD subtractor.
package bcd_serial_subtractor_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_RADIX   = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational one-digit BCD subtract: d = x - y - brw_in with borrow-out and invalid-digit flag.
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       brw_in,
  output logic [3:0] d,
  output logic       brw_out,
  output logic       bad
);

  localparam logic signed [4:0] RADIX_S = 5'(BCD_RADIX);
  localparam logic [3:0]        MAX_DIG = 4'(BCD_RADIX - 1);

  logic signed [4:0] t;

  // Range of t is -16..15, so the 5-bit signed difference never overflows even for raw nibbles.
  always_comb begin
    t       = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, brw_in});
    brw_out = t[4];
    d       = brw_out ? 4'(t + RADIX_S) : t[3:0];
    bad     = (x > MAX_DIG) || (y > MAX_DIG);
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor, diff = a - b - bin, one digit per clock LSD first, start/done handshake.
// Optional invalid-digit checking is enabled by defining BCD_CHECK_EN.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
  output logic                          bout,
  output logic                          err
);

  localparam int W  = BCD_DIGIT_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t               state, state_nxt;
  logic [W-1:0]         a_sh, b_sh;
  logic                 brw;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic [3:0]           dig;
  logic                 dig_brw;
  logic                 dig_bad;

  assign last = (cnt == CW'(DIGITS - 1));
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  bcd_digit_sub u_digit (
    .x       (a_sh[3:0]),
    .y       (b_sh[3:0]),
    .brw_in  (brw),
    .d       (dig),
    .brw_out (dig_brw),
    .bad     (dig_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef BCD_CHECK_EN
  logic bad_sticky, err_q;
  assign err = err_q;
`else
  logic unused_bad;
  assign unused_bad = dig_bad;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef BCD_CHECK_EN
      bad_sticky <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_sh <= a;
          b_sh <= b;
          brw  <= bin;
          cnt  <= '0;
          diff <= '0;
          bout <= 1'b0;
`ifdef BCD_CHECK_EN
          bad_sticky <= 1'b0;
          err_q      <= 1'b0;
`endif
        end
        // New digit enters at the MSD end so digit 0 ends up in bits [3:0].
        S_RUN: begin
          a_sh <= a_sh >> BCD_DIGIT_W;
          b_sh <= b_sh >> BCD_DIGIT_W;
          brw  <= dig_brw;
          diff <= {dig, diff[W-1:BCD_DIGIT_W]};
          cnt  <= last ? '0 : cnt + CW'(1);
          if (last) bout <= dig_brw;
`ifdef BCD_CHECK_EN
          bad_sticky <= bad_sticky | dig_bad;
          if (last && (bad_sticky || dig_bad)) begin
            diff  <= '0;
            bout  <= 1'b0;
            err_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=4); define BCD_CHECK_EN to cover digit checking.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        busy, done, bout, err;
  logic [15:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge with the DUT idle; returns #1 after the edge following done.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tbin, input logic [15:0] ed, input logic eb, input logic ee);
    int k, nbusy;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'hFFFF; b = 16'h5A5A; bin = ~tbin;
    k = 0; nbusy = 0;
    while (!done && k < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, k, DIGITS);
    check({tag, " busy"}, nbusy, DIGITS);
    check({tag, " diff"}, diff, ed);
    check({tag, " bout"}, bout, eb);
    check({tag, " err"}, err, ee);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
  endtask

  logic [15:0] qa [3] = '{16'h1234, 16'h0000, 16'h5000};
  logic [15:0] qb [3] = '{16'h0567, 16'h0001, 16'h4999};
  logic        qi [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] qd [3] = '{16'h0667, 16'h9999, 16'h0000};
  logic        qo [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int nacc, ndone, last_c, ndp;
    logic prev_busy;

    // Async reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    check("rst0 diff", diff, 0);
    check("rst0 busy", busy, 0);
    check("rst0 done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("op1234", 16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0);

    // Reset mid-cycle clears populated outputs immediately
    #2 rst = 1'b1;
    #1;
    check("rst1 diff", diff, 0);
    check("rst1 bout", bout, 0);
    check("rst1 busy", busy, 0);
    check("rst1 done", done, 0);
    check("rst1 err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("zero-1", 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0);
    run_op("5000-4999-1", 16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_op("a=b", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_op("0-0-1", 16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op("9999-0-1", 16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0);
    run_op("0500-0501", 16'h0500, 16'h0501, 1'b0, 16'h9999, 1'b1, 1'b0);

    // start held high across three back-to-back ops
    nacc = 0; ndone = 0; last_c = 0; prev_busy = 1'b0;
    a = qa[0]; b = qb[0]; bin = qi[0]; start = 1'b1;
    for (int c = 0; c < 60 && ndone < 3; c++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        nacc++;
        if (nacc < 3) begin
          a = qa[nacc]; b = qb[nacc]; bin = qi[nacc];
        end else start = 1'b0;
      end
      if (done) begin
        check("held diff", diff, qd[ndone]);
        check("held bout", bout, qo[ndone]);
        if (ndone > 0) check("held spacing", c - last_c, 6);
        last_c = c;
        ndone++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("held accepts", nacc, 3);
    check("held dones", ndone, 3);
    @(posedge clk); #1;

    // Reset two cycles after accept aborts the op
    a = 16'h1234; b = 16'h0567; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort diff", diff, 0);
    check("abort done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndp = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) ndp++;
    end
    check("abort no done", ndp, 0);
    run_op("after abort", 16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0);

`ifdef BCD_CHECK_EN
    run_op("bad digit", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_op("after bad", 16'h0010, 16'h0001, 1'b0, 16'h0009, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
